tx_completion_notifier: RTL and testbench
=========================================

Name: tx_completion_notifier

Overview:
- Transmit-side counterpart of the BAR2 host-write configuration path.
- When the TX engine finishes a huge page (`huge_page_free_1` or `huge_page_free_2` pulse), this block emits one posted Memory Write TLP on the TRN TX interface.
- The TLP carries a one-qword completion record and targets the host's completed-buffer address, so the driver learns which page can be refilled.
- It sits between the huge-page TX engine and the shared TRN TX arbiter.

Parameters:
- TLP_TAG, 8'h00, tag field placed in header DW1.
- TLP_ATTR, 2'b00, attr field placed in header DW0.

Ports:
- trn_clk  in  1  TRN user clock
- reset_n  in  1  async active-low reset (top drives ~trn_lnk_up_n)
- huge_page_free_1  in  1  one-cycle pulse: page 1 consumed
- huge_page_free_2  in  1  one-cycle pulse: page 2 consumed
- completed_buffer_address  in  64  host byte address of completion qword
- cfg_completer_id  in  16  requester ID {bus,dev,func}
- tx_request  out  1  TX arbiter request
- tx_grant  in  1  TX arbiter grant
- trn_tbuf_av  in  4  buffer availability; bit 1 = posted credit
- trn_td  out  64  TX data
- trn_trem_n  out  8  8'h00 = all bytes valid, 8'h0F = upper DW only
- trn_tsof_n  out  1  start of frame
- trn_teof_n  out  1  end of frame
- trn_tsrc_rdy_n  out  1  source ready
- trn_tsrc_dsc_n  out  1  tied 1
- trn_terrfwd_n  out  1  tied 1
- trn_tdst_rdy_n  in  1  destination ready

Behaviour:
- Reset (async, immediate):
  - trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=8'h00, trn_td=0, tx_request=0.
  - pending[2:1]=0, seq=32'd0, state=IDLE.
  - Reset mid-TLP abandons the frame: src_rdy deasserts at once; no pending work survives.
- Pending capture:
  - free_i pulse at edge k sets pending[i] at k.
  - If the same edge also clears pending[i] (its TLP completing), set wins.
  - Repeated pulses while pending merge into one notification.
- States:
  - IDLE: if pending!=0 and completed_buffer_address!=0 → REQ, with tx_request=1 from the next cycle.
    - Address 0 means not programmed; pending is held, nothing is sent.
  - REQ: when tx_grant=1 and trn_tbuf_av[1]=1 →
    - latch addr, seq and the service mask.
    - Service mask without coalescing = lowest pending bit (page 1 wins ties).
    - Move to B0.
  - B0: present beat 0 (tsof_n=0).
  - B1: present beat 1.
  - B2: present beat 2 (teof_n=0).
  - Each beat is held stable until accepted (tsrc_rdy_n=0 and tdst_rdy_n=0 on the same edge); acceptance advances the state.
  - src_rdy stays continuously asserted B0..B2; no gaps are inserted.
- EOF accept edge:
  - pending &= ~mask (subject to set-wins).
  - seq += 1 (wraps 2^32−1 → 0).
  - tx_request=0, state=IDLE.
  - Minimum one idle cycle between TLPs.
- Header DW0:
  - fmt/type = 7'b11_00000 for 64-bit address, or 7'b10_00000 for 32-bit address.
  - TC=0, TD=0, EP=0, attr=TLP_ATTR, length=10'd2.
- Header DW1: {cfg_completer_id, TLP_TAG, lastBE=4'hF, firstBE=4'hF}.
- Payload value:
  - V = {seq_latched, 30'b0, mask[2], mask[1]}.
  - PD0 = byte-swap(V[31:0]); PD1 = byte-swap(V[63:32]), where byte-swap(x) = {x[7:0],x[15:8],x[23:16],x[31:24]}.
- 4DW form (addr[63:32]!=0):
  - B0={DW0,DW1}
  - B1={addr[63:32], addr[31:3],3'b000}
  - B2={PD0,PD1}, trn_trem_n=8'h00
- 3DW form (addr[63:32]==0):
  - B0={DW0,DW1}
  - B1={addr[31:3],3'b000, PD0}
  - B2={PD1, 32'h0}, trn_trem_n=8'h0F
- Address bits [2:0] are forced to 0 (qword aligned).
- Changes to completed_buffer_address after REQ exit do not affect the frame in flight.

Optional Feature:
- Macro: NOTIFY_COALESCE_EN.
- Defined: at REQ exit, mask = all pending bits. One TLP may report both pages (low word 2'b11); seq increments once.
- Undefined: one page per TLP; page 1 is served before page 2.

Test Plan:
- Reset, address 64'h0000_0001_2345_6780, id 16'h0100:
  - free_1 pulse, grant=1, tbuf_av=4'h2, dst_rdy_n=0.
  - Required beats: 64'h6000_0002_0100_00FF, 64'h0000_0001_2345_6780, 64'h0100_0000_0000_0000; trn_trem_n=8'h00; seq becomes 1.
- Address 64'h0000_0000_8000_1000, free_2 pulse:
  - 3DW frame, B0 upper DW 32'h4000_0002, B1 = 64'h8000_1000_0200_0000, B2 = 64'h0000_0000_0000_0000 (seq 0), trn_trem_n=8'h0F.
- free_1 and free_2 on the same edge, macro off:
  - two TLPs, masks 2'b01 then 2'b10, seq 0 then 1.
  - Macro on: single TLP, low word 32'h3, seq 0.
- Backpressure: hold tdst_rdy_n=1 for 5 cycles during B1:
  - trn_td and trn_tsof_n/teof_n unchanged; frame completes normally afterwards.
- trn_tbuf_av[1]=0 for 10 cycles, and separately completed_buffer_address=0:
  - no tsof in either case; TLP is sent only once credit is restored and the address is programmed.
- reset_n low during B1:
  - trn_tsrc_rdy_n=1 immediately, tx_request=0, pending cleared; no TLP after reset release.

Source files
------------

// File: rtl/tx_completion_notifier.sv
`default_nettype none
// ============================================================================
// Module      : tx_completion_notifier
// Description : Emits one posted MWr TLP carrying a completion record each time
//               a huge page is freed. NOTIFY_COALESCE_EN folds all pending pages
//               into one TLP.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_completion_notifier #(
  parameter logic [7:0] TLP_TAG  = 8'h00,
  parameter logic [1:0] TLP_ATTR = 2'b00
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic        huge_page_free_1,
  input  logic        huge_page_free_2,
  input  logic [63:0] completed_buffer_address,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_request,
  input  logic        tx_grant,
  input  logic [3:0]  trn_tbuf_av,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  output logic        trn_terrfwd_n,
  input  logic        trn_tdst_rdy_n
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_B0   = 3'd2,
    ST_B1   = 3'd3,
    ST_B2   = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_pending;   // bit 0 = page 1, bit 1 = page 2
  logic [1:0]  r_mask;
  logic [31:0] r_seq;
  logic [31:0] r_seq_lat;
  logic [63:0] r_addr;
  logic        r_is_4dw;

  logic        w_accept;
  logic        w_eof_accept;
  logic        w_go;
  logic        w_live_4dw;
  logic [1:0]  w_set;
  logic [1:0]  w_clr;
  logic [1:0]  w_req_mask;
  logic [31:0] w_dw0;
  logic [31:0] w_dw1;
  logic [31:0] w_pd0;
  logic [31:0] w_pd1;
  logic [63:0] w_beat1;
  logic [63:0] w_beat2;
  logic        w_unused_tbuf;

  function automatic logic [31:0] byte_swap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign trn_tsrc_dsc_n = 1'b1;
  assign trn_terrfwd_n  = 1'b1;
  assign w_unused_tbuf  = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};

  assign w_accept     = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
  assign w_eof_accept = (r_state == ST_B2) & w_accept;
  assign w_go         = (r_state == ST_REQ) & tx_grant & trn_tbuf_av[1];
  assign w_set        = {huge_page_free_2, huge_page_free_1};
  assign w_clr        = w_eof_accept ? r_mask : 2'b00;
  assign w_live_4dw   = |completed_buffer_address[63:32];

`ifdef NOTIFY_COALESCE_EN
  assign w_req_mask = r_pending;
`else
  // Page 1 always goes first when both are waiting.
  assign w_req_mask = r_pending[0] ? 2'b01 : (r_pending & 2'b10);
`endif

  assign w_dw0 = {1'b0, (w_live_4dw ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000,
                  4'b0000, 1'b0, 1'b0, TLP_ATTR, 2'b00, 10'd2};
  assign w_dw1 = {cfg_completer_id, TLP_TAG, 4'hF, 4'hF};

  assign w_pd0 = byte_swap({30'b0, r_mask});
  assign w_pd1 = byte_swap(r_seq_lat);

  assign w_beat1 = r_is_4dw ? {r_addr[63:32], r_addr[31:3], 3'b000}
                            : {r_addr[31:3], 3'b000, w_pd0};
  assign w_beat2 = r_is_4dw ? {w_pd0, w_pd1} : {w_pd1, 32'h0};

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_pending      <= 2'b00;
      r_mask         <= 2'b00;
      r_seq          <= 32'd0;
      r_seq_lat      <= 32'd0;
      r_addr         <= 64'd0;
      r_is_4dw       <= 1'b0;
      tx_request     <= 1'b0;
      trn_td         <= 64'd0;
      trn_trem_n     <= 8'h00;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
    end else begin
      // A new free pulse overrides the clear of a TLP finishing on the same edge.
      r_pending <= (r_pending & ~w_clr) | w_set;

      case (r_state)
        ST_IDLE: begin
          if ((|r_pending) && (|completed_buffer_address)) begin
            r_state    <= ST_REQ;
            tx_request <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_go) begin
            r_state        <= ST_B0;
            r_mask         <= w_req_mask;
            r_seq_lat      <= r_seq;
            r_addr         <= {completed_buffer_address[63:3], 3'b000};
            r_is_4dw       <= w_live_4dw;
            trn_td         <= {w_dw0, w_dw1};
            trn_trem_n     <= 8'h00;
            trn_tsof_n     <= 1'b0;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b0;
          end
        end
        ST_B0: begin
          if (w_accept) begin
            r_state    <= ST_B1;
            trn_td     <= w_beat1;
            trn_tsof_n <= 1'b1;
          end
        end
        ST_B1: begin
          if (w_accept) begin
            r_state    <= ST_B2;
            trn_td     <= w_beat2;
            trn_teof_n <= 1'b0;
            trn_trem_n <= r_is_4dw ? 8'h00 : 8'h0F;
          end
        end
        ST_B2: begin
          if (w_accept) begin
            r_state        <= ST_IDLE;
            r_seq          <= r_seq + 32'd1;
            tx_request     <= 1'b0;
            trn_td         <= 64'd0;
            trn_trem_n     <= 8'h00;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_completion_notifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_completion_notifier
// Description : Directed and randomized bench for tx_completion_notifier with a
//               frame-level reference model of the completion TLP.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_completion_notifier;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        huge_page_free_1 = 1'b0;
  logic        huge_page_free_2 = 1'b0;
  logic [63:0] completed_buffer_address = 64'd0;
  logic [15:0] cfg_completer_id = 16'h0100;
  logic        tx_request;
  logic        tx_grant = 1'b1;
  logic [3:0]  trn_tbuf_av = 4'h2;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_terrfwd_n;
  logic        trn_tdst_rdy_n = 1'b0;

  tx_completion_notifier dut (
    .trn_clk                  (trn_clk),
    .reset_n                  (reset_n),
    .huge_page_free_1         (huge_page_free_1),
    .huge_page_free_2         (huge_page_free_2),
    .completed_buffer_address (completed_buffer_address),
    .cfg_completer_id         (cfg_completer_id),
    .tx_request               (tx_request),
    .tx_grant                 (tx_grant),
    .trn_tbuf_av              (trn_tbuf_av),
    .trn_td                   (trn_td),
    .trn_trem_n               (trn_trem_n),
    .trn_tsof_n               (trn_tsof_n),
    .trn_teof_n               (trn_teof_n),
    .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n           (trn_tsrc_dsc_n),
    .trn_terrfwd_n            (trn_terrfwd_n),
    .trn_tdst_rdy_n           (trn_tdst_rdy_n)
  );

  always #5 trn_clk = ~trn_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [1:0]  m_pending = 2'b00;
  logic [1:0]  m_mask    = 2'b00;
  logic [31:0] m_seq     = 32'd0;
  logic [31:0] f_seq     = 32'd0;
  logic [63:0] f_addr    = 64'd0;
  logic [15:0] f_id      = 16'd0;
  logic [63:0] fb [3];
  logic [63:0] last_b [3];
  logic [7:0]  last_trem = 8'h00;
  logic [63:0] log_b1 [$];
  logic [63:0] log_b2 [$];
  int          nb = 0;
  int          frames = 0;
  int          starts = 0;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [1:0] pick_mask(input logic [1:0] p);
`ifdef NOTIFY_COALESCE_EN
    return p;
`else
    if (p[0]) return 2'b01;
    return p & 2'b10;
`endif
  endfunction

  // Whole TLP as a list of DWs, padded to a qword; beats are consecutive DW pairs.
  function automatic logic [191:0] build_tlp(input logic [63:0] addr, input logic [31:0] seq,
                                             input logic [1:0] mask, input logic [15:0] id,
                                             output int ndw);
    logic [31:0] dws [6];
    logic [63:0] v;
    bit four;
    int n;
    for (int i = 0; i < 6; i++) dws[i] = 32'h0;
    four = (addr[63:32] != 32'h0);
    dws[0] = {1'b0, (four ? 2'b11 : 2'b10), 5'b0, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, 10'd2};
    dws[1] = {id, 8'h00, 8'hFF};
    n = 2;
    if (four) begin
      dws[n] = addr[63:32];
      n++;
    end
    dws[n] = {addr[31:3], 3'b000};
    n++;
    v = {seq, 30'b0, mask};
    dws[n] = bswap(v[31:0]);
    n++;
    dws[n] = bswap(v[63:32]);
    n++;
    ndw = n;
    return {dws[0], dws[1], dws[2], dws[3], dws[4], dws[5]};
  endfunction

  task automatic model_reset();
    m_pending = 2'b00;
    m_seq     = 32'd0;
    nb        = 0;
    log_b1.delete();
    log_b2.delete();
  endtask

  // One clock: sample pre-edge, advance, then check and update the model.
  task automatic step();
    logic        acc, pre_src_n, pre_sof_n, pre_eof_n, pre_req, go;
    logic [63:0] pre_td, cur_addr;
    logic [7:0]  pre_trem;
    logic [15:0] cur_id;
    logic [1:0]  pulses, pend_prev;
    logic [191:0] tlp;
    int ndw;
    pre_src_n = trn_tsrc_rdy_n;
    pre_sof_n = trn_tsof_n;
    pre_eof_n = trn_teof_n;
    pre_td    = trn_td;
    pre_trem  = trn_trem_n;
    pre_req   = tx_request;
    acc       = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    go        = tx_grant && trn_tbuf_av[1];
    pulses    = {huge_page_free_2, huge_page_free_1};
    pend_prev = m_pending;
    cur_addr  = completed_buffer_address;
    cur_id    = cfg_completer_id;
    @(posedge trn_clk);
    #1;
    huge_page_free_1 = 1'b0;
    huge_page_free_2 = 1'b0;
    if (acc) begin
      check_value("sof_position", pre_sof_n, (nb != 0));
      if (nb < 3) fb[nb] = pre_td;
      nb++;
      if (!pre_eof_n) begin
        tlp = build_tlp(f_addr, f_seq, m_mask, f_id, ndw);
        check_value("beat_count", nb, 3);
        check_value("beat0", fb[0], tlp[191:128]);
        check_value("beat1", fb[1], tlp[127:64]);
        check_value("beat2", fb[2], tlp[63:0]);
        check_value("trem", pre_trem, (ndw % 2) ? 8'h0F : 8'h00);
        check_value("eof_release", {trn_tsrc_rdy_n, tx_request}, 2'b10);
        for (int i = 0; i < 3; i++) last_b[i] = fb[i];
        last_trem = pre_trem;
        log_b1.push_back(fb[1]);
        log_b2.push_back(fb[2]);
        m_pending = m_pending & ~m_mask;
        m_seq     = m_seq + 32'd1;
        frames++;
      end else begin
        check_value("no_gap", trn_tsrc_rdy_n, 1'b0);
      end
    end else if (!pre_src_n) begin
      check_value("hold_td", trn_td, pre_td);
      check_value("hold_ctl", {trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n},
                  {pre_sof_n, pre_eof_n, pre_trem, 1'b0});
    end
    if (pre_src_n && !trn_tsrc_rdy_n) begin
      check_value("start_sof", trn_tsof_n, 1'b0);
      check_value("start_cond", {pre_req, go, (cur_addr != 64'd0)}, 3'b111);
      m_mask = pick_mask(pend_prev);
      f_addr = cur_addr;
      f_id   = cur_id;
      f_seq  = m_seq;
      nb     = 0;
      starts++;
    end
    m_pending = m_pending | pulses;
  endtask

  task automatic drain(input string tag);
    int i;
    step();
    for (i = 0; i < 300; i++) begin
      if (m_pending == 2'b00 && trn_tsrc_rdy_n && !tx_request) break;
      step();
    end
    check_value(tag, (i < 300), 1'b1);
  endtask

  task automatic wait_beat(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!trn_tsrc_rdy_n && ((which == 1 && trn_tsof_n && trn_teof_n) ||
                              (which == 2 && !trn_teof_n))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input bit chk);
    reset_n          = 1'b0;
    huge_page_free_1 = 1'b0;
    huge_page_free_2 = 1'b0;
    tx_grant         = 1'b1;
    trn_tbuf_av      = 4'h2;
    trn_tdst_rdy_n   = 1'b0;
    repeat (2) @(posedge trn_clk);
    #1;
    if (chk) begin
      check_value("rst_ctl", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, tx_request}, 4'b1110);
      check_value("rst_trem", trn_trem_n, 8'h00);
      check_value("rst_td", trn_td, 64'd0);
      check_value("rst_tied", {trn_tsrc_dsc_n, trn_terrfwd_n}, 2'b11);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit ok;
    int f0, s0;
    logic [63:0] held;

    // 4DW frame, then a second frame to expose the incremented sequence
    do_reset(1'b1);
    completed_buffer_address = 64'h0000_0001_2345_6780;
    cfg_completer_id = 16'h0100;
    huge_page_free_1 = 1'b1;
    drain("t1_drain");
    check_value("t1_b0", last_b[0], 64'h6000_0002_0100_00FF);
    check_value("t1_b1", last_b[1], 64'h0000_0001_2345_6780);
    check_value("t1_b2", last_b[2], 64'h0100_0000_0000_0000);
    check_value("t1_trem", last_trem, 8'h00);
    huge_page_free_1 = 1'b1;
    drain("t1_drain2");
    check_value("t1_seq1", last_b[2], 64'h0100_0000_0100_0000);

    // Pulse landing on the EOF accept edge must survive
    huge_page_free_1 = 1'b1;
    wait_beat(2, ok);
    check_value("sw_reach_b2", ok, 1'b1);
    f0 = frames;
    huge_page_free_1 = 1'b1;
    drain("sw_drain");
    check_value("set_wins", frames - f0, 2);

    // 3DW frame
    do_reset(1'b0);
    completed_buffer_address = 64'h0000_0000_8000_1000;
    huge_page_free_2 = 1'b1;
    drain("t2_drain");
    check_value("t2_dw0", last_b[0][63:32], 32'h4000_0002);
    check_value("t2_b1", last_b[1], 64'h8000_1000_0200_0000);
    check_value("t2_b2", last_b[2], 64'h0);
    check_value("t2_trem", last_trem, 8'h0F);

    // Both pages freed on one edge
    do_reset(1'b0);
    completed_buffer_address = 64'h0000_0000_8000_1000;
    huge_page_free_1 = 1'b1;
    huge_page_free_2 = 1'b1;
    drain("t3_drain");
`ifdef NOTIFY_COALESCE_EN
    check_value("t3_frames", log_b1.size(), 1);
    check_value("t3_mask", log_b1[0][31:0], 32'h0300_0000);
    check_value("t3_seq", log_b2[0], 64'h0);
`else
    check_value("t3_frames", log_b1.size(), 2);
    check_value("t3_mask0", log_b1[0][31:0], 32'h0100_0000);
    check_value("t3_mask1", log_b1[1][31:0], 32'h0200_0000);
    check_value("t3_seq1", log_b2[1][63:32], 32'h0100_0000);
`endif

    // Backpressure during beat 1
    completed_buffer_address = 64'h0000_0001_2345_6780;
    huge_page_free_1 = 1'b1;
    wait_beat(1, ok);
    check_value("bp_reach_b1", ok, 1'b1);
    held = trn_td;
    trn_tdst_rdy_n = 1'b1;
    repeat (5) step();
    check_value("bp_td", trn_td, held);
    check_value("bp_ctl", {trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, 3'b110);
    trn_tdst_rdy_n = 1'b0;
    drain("bp_drain");

    // No posted credit, then no programmed address
    s0 = starts;
    trn_tbuf_av = 4'h0;
    huge_page_free_1 = 1'b1;
    repeat (10) step();
    check_value("no_credit", starts - s0, 0);
    trn_tbuf_av = 4'h2;
    drain("credit_drain");
    check_value("credit_sent", starts - s0, 1);
    s0 = starts;
    completed_buffer_address = 64'h0;
    huge_page_free_2 = 1'b1;
    repeat (10) step();
    check_value("no_addr", {starts - s0, 31'd0, tx_request}, 64'h0);
    completed_buffer_address = 64'h0000_0000_8000_1000;
    drain("addr_drain");
    check_value("addr_sent", starts - s0, 1);

    // Reset in the middle of a frame
    completed_buffer_address = 64'h0000_0001_2345_6780;
    huge_page_free_1 = 1'b1;
    wait_beat(1, ok);
    check_value("rst_reach_b1", ok, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("rst_async", {trn_tsrc_rdy_n, tx_request}, 2'b10);
    @(posedge trn_clk);
    @(posedge trn_clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    s0 = starts;
    repeat (20) step();
    check_value("rst_no_tlp", {starts - s0, 31'd0, tx_request}, 64'h0);

    // Randomized traffic against the frame model
    do_reset(1'b0);
    completed_buffer_address = 64'h0000_0000_0000_1008;
    for (int c = 0; c < 800; c++) begin
      huge_page_free_1 = ($urandom_range(0, 9) == 0);
      huge_page_free_2 = ($urandom_range(0, 9) == 0);
      tx_grant         = ($urandom_range(0, 3) != 0);
      trn_tbuf_av      = 4'($urandom_range(0, 15));
      trn_tdst_rdy_n   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0)
        completed_buffer_address = {($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0,
                                    32'($urandom) | 32'h8};
      if ($urandom_range(0, 29) == 0)
        cfg_completer_id = 16'($urandom);
      step();
    end
    tx_grant       = 1'b1;
    trn_tbuf_av    = 4'h2;
    trn_tdst_rdy_n = 1'b0;
    drain("rand_drain");
    check_value("rand_frames", (frames > 10), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
